// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU control codes shared with the decoder, default widths and multi-cycle ALU states
package alu_ctrl_pkg;
  localparam int ALU_DATA_W = 32;
  localparam int ALU_CTRL_W = 4;
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLTU = 4'd5;
  localparam logic [3:0] ALU_BNE  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SLLV = 4'd8;
  localparam logic [3:0] ALU_LUI  = 4'd9;
  localparam logic [3:0] ALU_ORI  = 4'd10;
  localparam logic [3:0] ALU_MULT = 4'd11;
  typedef enum logic [1:0] {IDLE, MUL, DONE} alu_state_t;
endpackage

// File: rtl/seq_mult_u32.sv
// seq_mult_u32: unsigned 32x32 shift-add multiplier, one partial product per cycle
module seq_mult_u32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [4:0] cnt;
  assign done = busy && cnt == 5'd31;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      product <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      mcand <= {32'h0, a};
      mplier <= b;
      product <= '0;
    end else if (busy) begin
      product <= mplier[0] ? product + mcand : product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 5'd1;
      busy <= !done;
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: execute-stage ALU, single-cycle ops plus iterative signed MULT with ready stall
module alu_mc
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ALUCtrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        shamt_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] hi_o,
  output logic              zero_o
);
  alu_state_t state;
  logic sign, accept, is_mult, mul_busy, mul_done;
  logic [DATA_W-1:0] res, mag1, mag2;
  logic [2*DATA_W-1:0] prod, sprod;
  assign accept = valid_i && ready_o && !flush_i;
  assign is_mult = ALUCtrl_i == ALU_MULT;
  // 0x80000000 negates to itself, which is exactly 2^31 read as unsigned
  assign mag1 = src1_i[DATA_W-1] ? -src1_i : src1_i;
  assign mag2 = src2_i[DATA_W-1] ? -src2_i : src2_i;
  assign sprod = sign ? -prod : prod;
  always_comb begin
    res = '0;
    case (ALUCtrl_i)
      ALU_AND:  res = src1_i & src2_i;
      ALU_OR:   res = src1_i | src2_i;
      ALU_ADD:  res = src1_i + src2_i;
      ALU_SUB:  res = src1_i - src2_i;
      ALU_SLT:  res = DATA_W'($signed(src1_i) < $signed(src2_i));
      ALU_SLTU: res = DATA_W'(src1_i < src2_i);
      ALU_BNE:  res = src1_i - src2_i;
      ALU_SLL:  res = src2_i << shamt_i;
      ALU_SLLV: res = src2_i << src1_i[4:0];
      ALU_LUI:  res = {src2_i[15:0], 16'h0};
      ALU_ORI:  res = src1_i | {16'h0, src2_i[15:0]};
      default:  res = '0;
    endcase
  end
  seq_mult_u32 u_mult (
    .clk(clk_i),
    .rst(rst_i),
    .start(accept && is_mult && !mul_busy),
    .abort(flush_i),
    .a(mag1),
    .b(mag2),
    .busy(mul_busy),
    .done(mul_done),
    .product(prod)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      result_o <= '0;
      hi_o <= '0;
      zero_o <= 1'b0;
      sign <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE:
          if (accept && is_mult) begin
            state <= MUL;
            ready_o <= 1'b0;
            sign <= src1_i[DATA_W-1] ^ src2_i[DATA_W-1];
          end else if (accept) begin
            valid_o <= 1'b1;
            result_o <= res;
            hi_o <= '0;
            zero_o <= (ALUCtrl_i == ALU_BNE) ? res != '0 : res == '0;
          end
        MUL:
          if (flush_i) begin
            state <= IDLE;
            ready_o <= 1'b1;
          end else if (mul_done) state <= DONE;
        DONE: begin
          state <= IDLE;
          ready_o <= 1'b1;
          if (!flush_i) begin
            valid_o <= 1'b1;
            {hi_o, result_o} <= sprod;
            zero_o <= sprod[DATA_W-1:0] == '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc against a behavioural reference model
module tb_alu_mc;
  import alu_ctrl_pkg::*;
  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
  } exp_t;
  logic clk_i = 0, rst_i = 1, valid_i = 0, flush_i = 0;
  logic [3:0] ALUCtrl_i = 0;
  logic [31:0] src1_i = 0, src2_i = 0;
  logic [4:0] shamt_i = 0;
  logic ready_o, valid_o, zero_o;
  logic [31:0] result_o, hi_o;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  logic [31:0] last_res, last_hi;
  logic last_zero;
  alu_mc dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .valid_i(valid_i),
    .ALUCtrl_i(ALUCtrl_i),
    .src1_i(src1_i),
    .src2_i(src2_i),
    .shamt_i(shamt_i),
    .flush_i(flush_i),
    .ready_o(ready_o),
    .valid_o(valid_o),
    .result_o(result_o),
    .hi_o(hi_o),
    .zero_o(zero_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t r;
    longint p;
    r = '0;
    p = longint'($signed(a)) * longint'($signed(b));
    case (op)
      0: r.res = a & b;
      1: r.res = a | b;
      2: r.res = a + b;
      3: r.res = a - b;
      4: r.res = ($signed(a) < $signed(b)) ? 1 : 0;
      5: r.res = (a < b) ? 1 : 0;
      6: r.res = a - b;
      7: r.res = b << sh;
      8: r.res = b << a[4:0];
      9: r.res = {b[15:0], 16'h0};
      10: r.res = a | {16'h0, b[15:0]};
      11: begin r.res = p[31:0]; r.hi = p[63:32]; end
      default: r.res = 0;
    endcase
    r.zero = (op == 6) ? (r.res != 0) : (r.res == 0);
    return r;
  endfunction
  always @(negedge clk_i) begin
    if (rst_i) begin
      last_res = 0;
      last_hi = 0;
      last_zero = 0;
    end else if (valid_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected valid_o: result %h hi %h", result_o, hi_o);
      end else begin
        e = q.pop_front();
        check("result", {33'h0, result_o}, {33'h0, e.res});
        check("hi", {33'h0, hi_o}, {33'h0, e.hi});
        check("zero", {64'h0, zero_o}, {64'h0, e.zero});
      end
      last_res = result_o;
      last_hi = hi_o;
      last_zero = zero_o;
    end else check("hold", {zero_o, result_o, hi_o}, {last_zero, last_res, last_hi});
  end
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    int n = 0;
    @(negedge clk_i);
    valid_i = 1;
    ALUCtrl_i = op;
    src1_i = a;
    src2_i = b;
    shamt_i = sh;
    while (!ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready timeout: ready_o %b expected 1", ready_o);
    end else q.push_back(model(op, a, b, sh));
    @(posedge clk_i);
    #1 valid_i = 0;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int n;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    check("reset", {ready_o, valid_o, zero_o, result_o, hi_o[29:0]}, {1'b1, 64'h0});
    issue(ALU_ADD, 7, 32'hFFFFFFFD, 0);
    issue(ALU_SUB, 5, 5, 0);
    issue(ALU_BNE, 5, 5, 0);
    issue(ALU_BNE, 5, 6, 0);
    issue(ALU_SLT, 32'hFFFFFFFF, 1, 0);
    issue(ALU_SLTU, 32'hFFFFFFFF, 1, 0);
    issue(ALU_SLL, 0, 1, 31);
    issue(ALU_SLLV, 32'h23, 1, 0);
    issue(ALU_LUI, 0, 32'h1234, 0);
    issue(ALU_ORI, 32'hF0000000, 32'hFFFF00FF, 0);
    for (int c = 12; c < 16; c++) issue(4'(c), $urandom, $urandom, 0);
    issue(ALU_MULT, 32'hFFFFFFFD, 32'h40000000, 0);
    n = 0;
    while (!ready_o && n < 100) begin
      n++;
      @(posedge clk_i);
      #1;
    end
    check("mult ready low cycles", 65'(n), 65'd33);
    issue(ALU_MULT, 32'h80000000, 32'h80000000, 0);
    issue(ALU_MULT, 32'h12345678, 32'h9ABCDEF0, 0);
    repeat (10) @(posedge clk_i);
    #1 flush_i = 1;
    @(posedge clk_i);
    #1 flush_i = 0;
    q.delete(q.size() - 1);
    check("flush ready", {64'h0, ready_o}, 65'h1);
    issue(ALU_ADD, 1, 1, 0);
    issue(ALU_MULT, 32'hDEADBEEF, 32'h0000BEEF, 0);
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1;
    #1 check("async reset", {ready_o, valid_o, zero_o, result_o, hi_o[29:0]}, {1'b1, 64'h0});
    check("async reset hi", {33'h0, hi_o}, 65'h0);
    q.delete();
    @(posedge clk_i);
    #1 rst_i = 0;
    for (int i = 0; i < 300; i++) begin
      issue(($urandom_range(0, 9) == 0) ? ALU_MULT : 4'($urandom_range(0, 15)), pick(), pick(),
            5'($urandom));
      repeat ($urandom_range(0, 1)) @(negedge clk_i);
    end
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    check("drain", 65'(q.size()), 65'd0);
    @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
